// File: rtl/si_tag_pkg.sv
// si_tag_pkg
//   Shared constants, types and helpers for the tag lane scheduler.
//   - TAG_TIME_WIDTH / CHANNEL_WIDTH : field widths of one tag.
//   - tag_t                          : one buffered tag {tagtime, channel}.
//   - chan_to_enable_bit()           : maps a signed channel number onto its
//                                      bit in the channel_enable vector.
package si_tag_pkg;

  localparam int TAG_TIME_WIDTH   = 64;
  localparam int CHANNEL_WIDTH    = 6;
  localparam int ENABLE_IDX_WIDTH = 16;

  typedef struct packed {
    logic [TAG_TIME_WIDTH-1:0]       tagtime;
    logic signed [CHANNEL_WIDTH-1:0] channel;
  } tag_t;

  typedef struct packed {
    logic                        in_range;
    logic [ENABLE_IDX_WIDTH-1:0] idx;
  } chan_map_t;

  // Rising channel c (1..N) uses bit c-1; falling channel -c uses bit N+c-1.
  // Channel 0 and |ch| > N are reported as out of range (idx = 0).
  function automatic chan_map_t chan_to_enable_bit(
    input logic signed [CHANNEL_WIDTH-1:0] channel,
    input int                              channel_count
  );
    chan_map_t r;
    int        c;
    c = channel;
    r = '0;
    if (c > 0 && c <= channel_count) begin
      r.in_range = 1'b1;
      r.idx      = ENABLE_IDX_WIDTH'(c - 1);
    end else if (c < 0 && -c <= channel_count) begin
      r.in_range = 1'b1;
      r.idx      = ENABLE_IDX_WIDTH'(channel_count - c - 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/si_lowest_bit_select.sv
// si_lowest_bit_select
//   Purely combinational lowest-set-bit finder.
//   Ports:
//     vec       in  WIDTH      input mask
//     onehot    out WIDTH      only the lowest set bit of vec (0 if none)
//     idx       out IDX_WIDTH  index of the lowest set bit (0 if none)
//     any       out 1          vec has at least one bit set
//     is_onehot out 1          vec has exactly one bit set
module si_lowest_bit_select #(
  parameter int WIDTH     = 4,
  parameter int IDX_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0]     vec,
  output logic [WIDTH-1:0]     onehot,
  output logic [IDX_WIDTH-1:0] idx,
  output logic                 any,
  output logic                 is_onehot
);

  // Scan from the top down so the last hit written is the lowest one.
  always_comb begin
    onehot = '0;
    idx    = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
        idx       = IDX_WIDTH'(i);
      end
    end
  end

  assign any       = |vec;
  assign is_onehot = any && (vec == onehot);

endmodule

// File: rtl/si_tag_lane_scheduler.sv
// si_tag_lane_scheduler
//   Serialises a multi-lane tag beat into one tag per cycle, dropping lanes
//   whose channel is disabled, and backpressures the source while draining.
//   Ports:
//     clk, rst_n        clock, asynchronous active-low reset
//     s_axis_*          input beat: tvalid/tready, per-lane tagtime/channel,
//                       tkeep lane-valid mask
//     channel_enable    per-channel enable, sampled at beat acceptance
//     m_axis_*          output stream: one tag per handshake, tlast marks the
//                       final surviving tag of the beat
//     tag_count         emitted tags (wraps)
//     filtered_count    valid lanes dropped by the enable mask (wraps)
module si_tag_lane_scheduler
  import si_tag_pkg::*;
#(
  parameter int CHANNEL_COUNT   = 20,
  parameter int NUMBER_OF_WORDS = 4,
  parameter int LANE_IDX_WIDTH  = (NUMBER_OF_WORDS > 1) ? $clog2(NUMBER_OF_WORDS) : 1
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      s_axis_tvalid,
  output logic                                      s_axis_tready,
  input  logic [TAG_TIME_WIDTH*NUMBER_OF_WORDS-1:0] s_axis_tagtime,
  input  logic [CHANNEL_WIDTH*NUMBER_OF_WORDS-1:0]  s_axis_channel,
  input  logic [NUMBER_OF_WORDS-1:0]                s_axis_tkeep,
  input  logic [2*CHANNEL_COUNT-1:0]                channel_enable,
  output logic                                      m_axis_tvalid,
  input  logic                                      m_axis_tready,
  output logic [TAG_TIME_WIDTH-1:0]                 m_axis_tagtime,
  output logic signed [CHANNEL_WIDTH-1:0]           m_axis_channel,
  output logic                                      m_axis_tlast,
  output logic [31:0]                               tag_count,
  output logic [31:0]                               filtered_count
);

  localparam int ENABLE_WIDTH = 2 * CHANNEL_COUNT;

  tag_t                       buf_reg [NUMBER_OF_WORDS];
  logic [NUMBER_OF_WORDS-1:0] pending_reg;
  logic [31:0]                tag_count_reg;
  logic [31:0]                filtered_count_reg;

  logic [NUMBER_OF_WORDS-1:0] enable_hit;
  logic [NUMBER_OF_WORDS-1:0] sel_onehot;
  logic [LANE_IDX_WIDTH-1:0]  sel_idx;
  logic                       any_pending;
  logic                       last_pending;
  logic                       accept;
  logic                       emit;
  logic [31:0]                filtered_inc;

  // Decoder-style lookup keeps the enable index width independent of the
  // (possibly non power-of-two) enable vector width.
  function automatic logic lane_enabled(
    input logic signed [CHANNEL_WIDTH-1:0] ch,
    input logic [ENABLE_WIDTH-1:0]         en
  );
    chan_map_t m;
    logic      hit;
    m   = chan_to_enable_bit(ch, CHANNEL_COUNT);
    hit = 1'b0;
    for (int b = 0; b < ENABLE_WIDTH; b++) begin
      if (m.idx == ENABLE_IDX_WIDTH'(b)) hit = en[b];
    end
    return m.in_range & hit;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NUMBER_OF_WORDS; gi++) begin : g_lane_hit
      assign enable_hit[gi] =
        lane_enabled(s_axis_channel[gi*CHANNEL_WIDTH +: CHANNEL_WIDTH], channel_enable);
    end
  endgenerate

  always_comb begin
    filtered_inc = '0;
    for (int i = 0; i < NUMBER_OF_WORDS; i++) begin
      if (s_axis_tkeep[i] && !enable_hit[i]) filtered_inc = filtered_inc + 32'd1;
    end
  end

  si_lowest_bit_select #(
    .WIDTH     (NUMBER_OF_WORDS),
    .IDX_WIDTH (LANE_IDX_WIDTH)
  ) u_sel (
    .vec       (pending_reg),
    .onehot    (sel_onehot),
    .idx       (sel_idx),
    .any       (any_pending),
    .is_onehot (last_pending)
  );

  // Ready when empty, or when the final tag leaves this very cycle so the
  // next beat can follow without a bubble.
  assign s_axis_tready = !any_pending || (last_pending && m_axis_tready);
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign emit          = any_pending && m_axis_tready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_reg        <= '0;
      tag_count_reg      <= '0;
      filtered_count_reg <= '0;
      for (int i = 0; i < NUMBER_OF_WORDS; i++) buf_reg[i] <= '0;
    end else begin
      // Acceptance only happens with the old mask empty or on its last
      // handshake, so overwriting the mask never loses a tag.
      if (accept) begin
        pending_reg        <= s_axis_tkeep & enable_hit;
        filtered_count_reg <= filtered_count_reg + filtered_inc;
        for (int i = 0; i < NUMBER_OF_WORDS; i++) begin
          buf_reg[i].tagtime <= s_axis_tagtime[i*TAG_TIME_WIDTH +: TAG_TIME_WIDTH];
          buf_reg[i].channel <= s_axis_channel[i*CHANNEL_WIDTH +: CHANNEL_WIDTH];
        end
      end else if (emit) begin
        pending_reg <= pending_reg & ~sel_onehot;
      end
      if (emit) tag_count_reg <= tag_count_reg + 32'd1;
    end
  end

  assign m_axis_tvalid  = any_pending;
  assign m_axis_tagtime = buf_reg[sel_idx].tagtime;
  assign m_axis_channel = buf_reg[sel_idx].channel;
  assign m_axis_tlast   = last_pending;
  assign tag_count      = tag_count_reg;
  assign filtered_count = filtered_count_reg;

endmodule

// File: doc/si_tag_lane_scheduler.md
Name: si_tag_lane_scheduler

Overview:
- Serialises the multi-lane tag output of the tag converter (up to NUMBER_OF_WORDS tags per beat) into a single-tag-per-cycle stream.
- Serves downstream consumers that process one tag per clock, such as histogrammers and coincidence logic.
- Filters tags by a per-channel enable mask at acceptance.
- Applies backpressure to the converter while a beat is still being drained.

Parameters:
- CHANNEL_COUNT, 20: internal channel count; channels are -CHANNEL_COUNT..-1 and 1..CHANNEL_COUNT.
- NUMBER_OF_WORDS, 4: tag lanes per input beat.
- LANE_IDX_WIDTH, $clog2(NUMBER_OF_WORDS) (minimum 1): lane index width.

Ports:
- clk  in  1  sole clock.
- rst_n  in  1  asynchronous, active-low reset.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tready  out  1  input beat accepted when high together with tvalid.
- s_axis_tagtime  in  64 x NUMBER_OF_WORDS  tag time per lane, in 1/3 ps.
- s_axis_channel  in  signed 6 x NUMBER_OF_WORDS  channel per lane.
- s_axis_tkeep  in  NUMBER_OF_WORDS  lane-valid mask.
- channel_enable  in  2*CHANNEL_COUNT  bit c-1 enables rising channel c; bit CHANNEL_COUNT+c-1 enables falling channel -c.
- m_axis_tvalid  out  1  output tag valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tagtime  out  64  tag time.
- m_axis_channel  out  signed 6  channel.
- m_axis_tlast  out  1  last tag taken from the current beat.
- tag_count  out  32  number of emitted tags; wraps modulo 2^32.
- filtered_count  out  32  number of valid lanes dropped by the enable mask; wraps.

Behaviour:
- Storage: beat buffer holding NUMBER_OF_WORDS tagtime/channel entries, plus a pending mask of NUMBER_OF_WORDS bits.
- Reset (async assert, sync release):
  - pending = 0, buffer = 0, tag_count = 0, filtered_count = 0.
  - Hence m_axis_tvalid = 0, m_axis_tagtime = 0, m_axis_channel = 0, m_axis_tlast = 0.
  - A reset mid-drain discards the remaining pending tags; no partial output after release.
- s_axis_tready = (pending == 0) || (pending is one-hot && m_axis_tready).
  - Combinational from m_axis_tready.
  - Independent of s_axis_tvalid.
- Acceptance (s_axis_tvalid && s_axis_tready):
  - buffer <= input lanes.
  - pending <= s_axis_tkeep & enable_hit, where enable_hit[i] = channel_enable[map(s_axis_channel[i])].
  - channel_enable is sampled in the acceptance cycle only.
  - An out-of-range channel (0 or |ch| > CHANNEL_COUNT) counts as disabled.
  - filtered_count += popcount(s_axis_tkeep & ~enable_hit).
- Output:
  - sel = index of the lowest set pending bit (lane order equals time order).
  - m_axis_tvalid = |pending.
  - m_axis_tagtime / m_axis_channel = buffer[sel].
  - m_axis_tlast = pending is one-hot.
- Output handshake (m_axis_tvalid && m_axis_tready): clear pending[sel]; tag_count += 1.
- Simultaneous handshake on the last tag and a new acceptance in the same cycle: the new pending mask overwrites the old one; no bubble.
- Latency: a tag accepted in cycle t is presented in cycle t+1.
- Throughput: a beat with k surviving tags occupies max(k,1) cycles. Consecutive single-tag beats stream at 1 tag/cycle.
- A beat whose surviving mask is 0 is consumed in one cycle with no output.
- Output stability: while m_axis_tvalid && !m_axis_tready, the outputs hold stable (AXI-stream rule).
- No output reordering; no loss except by channel filtering.

Decomposition:
- Package si_tag_pkg holds:
  - constants TAG_TIME_WIDTH = 64 and CHANNEL_WIDTH = 6;
  - typedef tag_t {tagtime, channel};
  - function chan_to_enable_bit(channel, CHANNEL_COUNT) returning the index and an in-range flag.
- Sub-module si_lowest_bit_select (parameter WIDTH): outputs the lowest-set one-hot, its index, an any flag and an is-onehot flag. Purely combinational, reused for sel and tlast.

Test Plan:
- Reset, then a beat with tkeep=4'b1011, channels {3,-2,x,5}, times {100,200,x,400}, all channels enabled, m_axis_tready=1 -> tags 100/3, 200/-2, 400/5 on cycles t+1..t+3. tlast only on 400. s_axis_tready low on t+1, t+2 and high on t+3. tag_count=3.
- Back-to-back beats, each tkeep=4'b0001, times 10, 20, 30, tready held 1 -> one tag per cycle with no bubble, tlast=1 on every tag.
- channel_enable clears bit for channel 3; beat tkeep=4'b0011 with channels {3,7} -> only the channel-7 tag emitted, filtered_count=1. All-filtered beat -> consumed in 1 cycle, no m_axis_tvalid.
- m_axis_tready held low for 5 cycles mid-beat -> outputs hold stable, s_axis_tready=0; on release the drain continues in order.
- Invalid channel 0 and channel 21 with CHANNEL_COUNT=20 -> both dropped, filtered_count += 2.
- rst_n asserted asynchronously with 2 tags pending -> m_axis_tvalid falls immediately, counters read 0, and the next beat after release outputs normally.
